// File: rtl/z80_bus_tracer_pkg.sv
// Shared definitions for the Z80 bus tracer: cycle-type codes, capture FSM
// states, strobe bit positions and the cycle classifier.
package z80_bus_tracer_pkg;

  // Cycle-type codes stored in the top field of every trace record
  typedef enum logic [2:0] {
    CYC_MEMRD = 3'd0,
    CYC_MEMWR = 3'd1,
    CYC_IORD  = 3'd2,
    CYC_IOWR  = 3'd3,
    CYC_FETCH = 3'd4
  } cyc_type_e;

  // Capture FSM states, also driven out on the state port
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } tr_state_e;

  // Bit positions of the CPU strobes inside the packed strobe vector
  localparam int STB_RD   = 0;
  localparam int STB_WR   = 1;
  localparam int STB_IORQ = 2;
  localparam int STB_MREQ = 3;
  localparam int STB_M1   = 4;
  localparam int NUM_STB  = 5;

  // Record layout {type, addr, data}: type field width
  localparam int TYPE_W = 3;

  typedef struct packed {
    logic      valid;
    cyc_type_e ctype;
  } cyc_class_t;

  // Classify a cycle from active-high strobe levels; refresh and interrupt
  // acknowledge carry no RD/WR and come back as not valid.
  function automatic cyc_class_t classify(input logic [NUM_STB-1:0] act);
    cyc_class_t c;
    c.valid = 1'b1;
    c.ctype = CYC_MEMRD;
    if (act[STB_M1] && act[STB_MREQ] && act[STB_RD])  c.ctype = CYC_FETCH;
    else if (act[STB_MREQ] && act[STB_RD])            c.ctype = CYC_MEMRD;
    else if (act[STB_MREQ] && act[STB_WR])            c.ctype = CYC_MEMWR;
    else if (act[STB_IORQ] && act[STB_RD])            c.ctype = CYC_IORD;
    else if (act[STB_IORQ] && act[STB_WR])            c.ctype = CYC_IOWR;
    else                                              c.valid = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/z80_bus_tracer_ram.sv
// Trace storage: simple dual-port RAM, synchronous write, registered read.
// Only the read register is reset so the readout port starts at zero.
module z80_bus_tracer_ram #(
  parameter int DEPTH = 64,
  parameter int W     = 27
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port, holds the last popped record
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/z80_bus_tracer.sv
// Z80 bus tracer: synchronises the CPU strobes, classifies each bus cycle,
// records it into a circular trace buffer with trigger/post-trigger capture
// and raises WAIT on an address/cycle-type breakpoint.
//
// Readout handshake: rd_en is a request that is accepted only in IDLE/DONE
// with count>0; an accepted request pops the oldest record and rd_valid is
// high for exactly one clock on the following cycle with rd_data holding it.
module z80_bus_tracer
  import z80_bus_tracer_pkg::*;
#(
  parameter int AW          = 16,
  parameter int DW          = 8,
  parameter int DEPTH       = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [AW-1:0]          a_cpu,
  input  logic [DW-1:0]          d_cpu,
  input  logic                   rd_cpu,
  input  logic                   wr_cpu,
  input  logic                   io_req_cpu,
  input  logic                   mem_req_cpu,
  input  logic                   m1_cpu,
  input  logic                   arm,
  input  logic                   disarm,
  input  logic [$clog2(DEPTH):0] post_cnt,
  input  logic                   bp_en,
  input  logic [AW-1:0]          bp_addr,
  input  logic [AW-1:0]          bp_mask,
  input  logic [4:0]             bp_types,
  input  logic                   go_step,
  input  logic                   rd_en,
  output logic [TYPE_W+AW+DW-1:0] rd_data,
  output logic                   rd_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic [1:0]             state,
  output logic                   wait_n
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = TYPE_W + AW + DW;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // ---------------- strobe synchronisers (active-low levels) ----------------
  logic [NUM_STB-1:0] stb_raw;
  logic [NUM_STB-1:0] stb_s;
  logic               rd_p, wr_p;

  assign stb_raw = {m1_cpu, mem_req_cpu, io_req_cpu, wr_cpu, rd_cpu};

  for (genvar i = 0; i < NUM_STB; i++) begin : g_sync
    logic [SYNC_STAGES-1:0] chain;
    // Synchroniser chain, idles high like the inactive strobe
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) chain <= '1;
      else        chain <= {chain[SYNC_STAGES-2:0], stb_raw[i]};
    end
    assign stb_s[i] = chain[SYNC_STAGES-1];
  end

  // Previous synced RD/WR levels for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_p <= 1'b1;
      wr_p <= 1'b1;
    end else begin
      rd_p <= stb_s[STB_RD];
      wr_p <= stb_s[STB_WR];
    end
  end

  // ---------------- bus hold registers ----------------
  logic [AW-1:0] a_h;
  logic [DW-1:0] d_h;

  // One-stage hold of address/data, sampled every clock
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_h <= '0;
      d_h <= '0;
    end else begin
      a_h <= a_cpu;
      d_h <= d_cpu;
    end
  end

  // ---------------- cycle tracking ----------------
  cyc_class_t start_cls;
  logic       cyc_start, cyc_end, start_match;
  logic       in_cyc, cyc_is_rd, cyc_valid, cyc_match;
  cyc_type_e  cyc_type;

  assign start_cls   = classify(~stb_s);
  assign cyc_start   = (rd_p & wr_p) & ~(stb_s[STB_RD] & stb_s[STB_WR]);
  assign start_match = bp_en & start_cls.valid & bp_types[start_cls.ctype] &
                       (((a_h ^ bp_addr) & bp_mask) == '0);
  assign cyc_end     = in_cyc & (cyc_is_rd ? (~rd_p & stb_s[STB_RD])
                                           : (~wr_p & stb_s[STB_WR]));

  // Latch type, active strobe and breakpoint hit at cycle start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_cyc    <= 1'b0;
      cyc_is_rd <= 1'b0;
      cyc_valid <= 1'b0;
      cyc_match <= 1'b0;
      cyc_type  <= CYC_MEMRD;
    end else if (cyc_start) begin
      in_cyc    <= 1'b1;
      cyc_is_rd <= ~stb_s[STB_RD];
      cyc_valid <= start_cls.valid;
      cyc_match <= start_match;
      cyc_type  <= start_cls.ctype;
    end else if (cyc_end) begin
      in_cyc    <= 1'b0;
    end
  end

  // ---------------- WAIT request ----------------
  logic wait_q;

  // Set on a breakpoint hit, released by go_step (release has priority)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        wait_q <= 1'b0;
    else if (go_step)                  wait_q <= 1'b0;
    else if (cyc_start && start_match) wait_q <= 1'b1;
  end

  assign wait_n = ~wait_q;

  // ---------------- capture FSM ----------------
  tr_state_e      state_q, state_d;
  logic           capturing, readable;
  logic           clear, rec_wr, trig, post_last, pop;
  logic [CW-1:0]  post_rem;
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count_q;

  assign clear     = arm & ~disarm;
  assign rec_wr    = cyc_end & cyc_valid & capturing & ~arm & ~disarm;
  assign trig      = rec_wr & (state_q == ST_ARMED) & cyc_match;
  assign post_last = rec_wr & (state_q == ST_POST) & (post_rem == CW'(1));
  assign pop       = rd_en & readable & (count_q != '0) & ~clear;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; disarm beats arm, arm restarts capture
  always_comb begin
    state_d = state_q;
    if (disarm) begin
      state_d = ST_IDLE;
    end else if (arm) begin
      state_d = ST_ARMED;
    end else begin
      case (state_q)
        ST_ARMED: if (trig) state_d = (post_cnt == '0) ? ST_DONE : ST_POST;
        ST_POST:  if (post_last) state_d = ST_DONE;
        default:  state_d = state_q;
      endcase
    end
  end

  // State-decoded qualifiers
  always_comb begin
    capturing = 1'b0;
    readable  = 1'b0;
    case (state_q)
      ST_ARMED, ST_POST: capturing = 1'b1;
      default:           readable  = 1'b1;
    endcase
  end

  // Post-trigger countdown
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      post_rem <= '0;
    else if (trig)
      post_rem <= post_cnt;
    else if (rec_wr && state_q == ST_POST && post_rem != '0)
      post_rem <= post_rem - 1'b1;
  end

  // Circular buffer pointers and fill count; full buffer drops the oldest
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (rec_wr) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (count_q == FULL) rd_ptr  <= rd_ptr + 1'b1;
      else                 count_q <= count_q + 1'b1;
    end else if (pop) begin
      rd_ptr  <= rd_ptr + 1'b1;
      count_q <= count_q - 1'b1;
    end
  end

  // Read data strobe, one clock after an accepted pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_valid <= 1'b0;
    else        rd_valid <= pop;
  end

  logic [RW-1:0] rec_data;
  assign rec_data = {cyc_type, a_h, d_h};

  z80_bus_tracer_ram #(
    .DEPTH (DEPTH),
    .W     (RW)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (rec_wr),
    .waddr (wr_ptr),
    .wdata (rec_data),
    .re    (pop),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  assign count = count_q;
  assign state = state_q;

endmodule

// File: tb/tb_z80_bus_tracer.sv
// Bench for z80_bus_tracer: drives Z80-style bus cycles and checks the trace
// buffer, capture FSM and WAIT against a queue-level reference model.
module tb_z80_bus_tracer;

  localparam int AW    = 16;
  localparam int DW    = 8;
  localparam int DEPTH = 64;
  localparam int SYNC  = 2;
  localparam int RW    = 3 + AW + DW;
  localparam int CW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [AW-1:0] a_cpu, bp_addr, bp_mask;
  logic [DW-1:0] d_cpu;
  logic rd_cpu, wr_cpu, io_req_cpu, mem_req_cpu, m1_cpu;
  logic arm, disarm, bp_en, go_step, rd_en;
  logic [CW-1:0] post_cnt;
  logic [4:0]    bp_types;
  logic [RW-1:0] rd_data;
  logic          rd_valid, wait_n;
  logic [CW-1:0] count;
  logic [1:0]    state;

  z80_bus_tracer #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .a_cpu(a_cpu), .d_cpu(d_cpu),
    .rd_cpu(rd_cpu), .wr_cpu(wr_cpu), .io_req_cpu(io_req_cpu),
    .mem_req_cpu(mem_req_cpu), .m1_cpu(m1_cpu),
    .arm(arm), .disarm(disarm), .post_cnt(post_cnt),
    .bp_en(bp_en), .bp_addr(bp_addr), .bp_mask(bp_mask), .bp_types(bp_types),
    .go_step(go_step), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .count(count), .state(state), .wait_n(wait_n)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [RW-1:0] exp_q[$];
  int  m_state;      // 0 idle, 1 armed, 2 post, 3 done
  int  m_post_left;
  bit  m_wait;
  int  n_checks = 0;
  int  n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  // typ 0..4 as recorded codes, 5 = refresh (MREQ only), 6 = int-ack (M1+IORQ)
  task automatic bus_cycle(input int typ, input logic [15:0] a, input logic [7:0] d);
    int first_low;
    bit is_rd;
    bit exp_match;
    logic [RW-1:0] rec;
    exp_match = (typ <= 4) && bp_en && bp_types[typ] && (((a ^ bp_addr) & bp_mask) == 16'h0);
    @(negedge clk);
    a_cpu = a;
    d_cpu = d;
    case (typ)
      0, 1, 5: mem_req_cpu = 1'b0;
      2, 3:    io_req_cpu  = 1'b0;
      4:       begin m1_cpu = 1'b0; mem_req_cpu = 1'b0; end
      default: begin m1_cpu = 1'b0; io_req_cpu  = 1'b0; end
    endcase
    repeat (2) @(negedge clk);
    is_rd = (typ == 0 || typ == 2 || typ == 4);
    if (typ <= 4) begin
      if (is_rd) rd_cpu = 1'b0;
      else       wr_cpu = 1'b0;
    end
    first_low = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (first_low == 0 && wait_n == 1'b0) first_low = k;
    end
    if (exp_match)
      check("bp_latency_ok", 32'(first_low >= 1 && first_low <= SYNC + 1), 32'd1);
    rd_cpu = 1'b1; wr_cpu = 1'b1; mem_req_cpu = 1'b1; io_req_cpu = 1'b1; m1_cpu = 1'b1;
    repeat (3) @(negedge clk);
    a_cpu = 16'($urandom);
    d_cpu = 8'($urandom);
    // reference model update for this cycle
    if (typ <= 4) begin
      if (exp_match) m_wait = 1'b1;
      if (m_state == 1 || m_state == 2) begin
        rec = {typ[2:0], a, d};
        exp_q.push_back(rec);
        if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
        if (m_state == 1 && exp_match) begin
          if (post_cnt == 0) m_state = 3;
          else begin m_state = 2; m_post_left = int'(post_cnt); end
        end else if (m_state == 2) begin
          m_post_left--;
          if (m_post_left == 0) m_state = 3;
        end
      end
    end
    check("cyc_count", 32'(count), 32'(exp_q.size()));
    check("cyc_state", 32'(state), 32'(m_state));
    check("cyc_wait_n", 32'(wait_n), 32'(!m_wait));
  endtask

  task automatic ctl_pulse(input bit a, input bit d);
    @(negedge clk);
    arm = a; disarm = d;
    @(negedge clk);
    arm = 1'b0; disarm = 1'b0;
    if (d) m_state = 0;
    else if (a) begin m_state = 1; exp_q.delete(); end
    check("ctl_state", 32'(state), 32'(m_state));
    check("ctl_count", 32'(count), 32'(exp_q.size()));
  endtask

  task automatic step_release();
    @(negedge clk);
    go_step = 1'b1;
    @(negedge clk);
    go_step = 1'b0;
    m_wait = 1'b0;
    check("go_step_wait_n", 32'(wait_n), 32'd1);
  endtask

  task automatic pop_check(input string tag);
    logic [RW-1:0] e;
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    if ((m_state == 0 || m_state == 3) && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, 32'(rd_valid), 32'd1);
      check({tag, "_data"}, 32'(rd_data), 32'(e));
    end else begin
      check({tag, "_ignored"}, 32'(rd_valid), 32'd0);
    end
    check({tag, "_count"}, 32'(count), 32'(exp_q.size()));
  endtask

  task automatic drain(input string tag);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) pop_check(tag);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  logic [RW-1:0] rec41;

  initial begin
    reset = 1'b0;
    a_cpu = '0; d_cpu = '0;
    rd_cpu = 1'b1; wr_cpu = 1'b1; io_req_cpu = 1'b1; mem_req_cpu = 1'b1; m1_cpu = 1'b1;
    arm = 1'b0; disarm = 1'b0; go_step = 1'b0; rd_en = 1'b0;
    post_cnt = '0; bp_en = 1'b0; bp_addr = '0; bp_mask = '1; bp_types = '0;
    m_state = 0; m_post_left = 0; m_wait = 1'b0;
    rec41 = '0;

    repeat (3) @(negedge clk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_wait_n", 32'(wait_n), 32'd1);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // three memory writes, readout refused while armed, then ordered pops
    ctl_pulse(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) bus_cycle(1, 16'h8000 + 16'(i), 8'h11 + 8'(i));
    pop_check("pop_armed");
    ctl_pulse(1'b0, 1'b1);
    drain("pop_memwr");
    pop_check("pop_empty");

    // refresh and int-ack are not recorded; iord record layout
    ctl_pulse(1'b1, 1'b0);
    bus_cycle(0, 16'h1234, 8'hA5);
    bus_cycle(5, 16'h0042, 8'h00);
    bus_cycle(6, 16'h00FF, 8'hFF);
    bus_cycle(2, 16'h0080, 8'h5A);
    ctl_pulse(1'b0, 1'b1);
    pop_check("pop_memrd");
    pop_check("pop_iord");
    check("iord_record", 32'(rd_data), {5'd0, 3'd2, 16'h0080, 8'h5A});

    // arm+disarm together: disarm wins, buffer retained
    ctl_pulse(1'b1, 1'b0);
    bus_cycle(0, 16'h4000, 8'h01);
    bus_cycle(3, 16'h0010, 8'h02);
    ctl_pulse(1'b1, 1'b1);
    check("armdis_state", 32'(state), 32'd0);
    drain("pop_armdis");

    // breakpoint on fetch at 0x0100, active in IDLE
    bp_en = 1'b1; bp_addr = 16'h0100; bp_mask = 16'hFFFF; bp_types = 5'b10000;
    bus_cycle(4, 16'h0100, 8'h3E);
    step_release();
    bus_cycle(4, 16'h0101, 8'h3E);
    bus_cycle(0, 16'h0100, 8'h3E);
    bp_mask = 16'hFF00;
    bus_cycle(4, 16'h01C7, 8'h00);
    step_release();
    bp_mask = 16'hFFFF;

    // trigger at entry 100, post_cnt 4, buffer wraps
    post_cnt = CW'(4);
    ctl_pulse(1'b1, 1'b0);
    for (int i = 1; i <= 104; i++) begin
      int t;
      logic [15:0] a;
      logic [7:0]  d;
      t = (i == 100) ? 4 : $urandom_range(0, 3);
      a = (i == 100) ? 16'h0100 : 16'($urandom);
      d = 8'($urandom);
      if (i == 41) rec41 = {t[2:0], a, d};
      bus_cycle(t, a, d);
      if (m_wait) step_release();
    end
    check("wrap_state", 32'(state), 32'd3);
    check("wrap_count", 32'(count), 32'(DEPTH));
    bus_cycle($urandom_range(0, 3), 16'($urandom), 8'($urandom));
    pop_check("pop_wrap_first");
    check("wrap_first_is_41", 32'(rd_data), 32'(rec41));
    drain("pop_wrap");
    ctl_pulse(1'b0, 1'b1);

    // randomized breakpoint configurations and cycle mixes
    for (int r = 0; r < 4; r++) begin
      post_cnt = CW'($urandom_range(0, 5));
      bp_types = 5'($urandom);
      bp_mask  = (r % 2 == 0) ? 16'hFFFF : 16'hFFF0;
      ctl_pulse(1'b1, 1'b0);
      for (int i = 0; i < 24; i++) begin
        int t;
        logic [15:0] a;
        t = $urandom_range(0, 6);
        case ($urandom_range(0, 2))
          0:       a = 16'h0100;
          1:       a = 16'h0103;
          default: a = 16'($urandom);
        endcase
        bus_cycle(t, a, 8'($urandom));
        if (m_wait) step_release();
      end
      ctl_pulse(1'b0, 1'b1);
      drain("pop_rand");
    end

    // reset in the middle of POST with WAIT asserted
    bp_types = 5'b10000; bp_mask = 16'hFFFF; post_cnt = CW'(10);
    ctl_pulse(1'b1, 1'b0);
    bus_cycle(1, 16'h2000, 8'h77);
    bus_cycle(4, 16'h0100, 8'hC3);
    bus_cycle(0, 16'h2001, 8'h78);
    check("pre_rst_state", 32'(state), 32'd2);
    check("pre_rst_wait_n", 32'(wait_n), 32'd0);
    #2 reset = 1'b0;
    #1;
    exp_q.delete(); m_state = 0; m_wait = 1'b0;
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_wait_n", 32'(wait_n), 32'd1);
    check("midrst_rd_valid", 32'(rd_valid), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    pop_check("pop_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
